// File: rtl/axis_job_scheduler.sv
// Round-robin job scheduler sharing one AXI-Stream core between NUM_REQ requesters.
// Optional watchdog abort is compiled in with `define SCHED_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no job; arbitrate among valid requesters, one bubble cycle
// RUN   | job owned by grant; input and result paths pass through concurrently
module axis_job_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int FRAME_LEN      = 16,
  parameter int RESULT_LEN     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [NUM_REQ-1:0]    s_req_tvalid,
  output logic [NUM_REQ-1:0]    s_req_tready,
  input  logic [32*NUM_REQ-1:0] s_req_tdata,
  output logic                  core_in_tvalid,
  input  logic                  core_in_tready,
  output logic [31:0]           core_in_tdata,
  input  logic                  core_out_tvalid,
  output logic                  core_out_tready,
  input  logic [31:0]           core_out_tdata,
  output logic                  m_res_tvalid,
  input  logic                  m_res_tready,
  output logic [31:0]           m_res_tdata,
  output logic [ID_W-1:0]       m_res_tid,
  output logic                  m_res_tlast,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int IN_W  = $clog2(FRAME_LEN + 1);
  localparam int OUT_W = $clog2(RESULT_LEN + 1);

  if ((2 ** ID_W) < NUM_REQ || FRAME_LEN < 1 || RESULT_LEN < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("axis_job_scheduler: inconsistent parameters");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic [ID_W-1:0]   grant;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   next_grant;
  logic              found;
  logic [IN_W-1:0]   in_cnt;
  logic [OUT_W-1:0]  out_cnt;
  logic              run;
  logic              in_done;
  logic              out_done;
  logic              in_hs;
  logic              out_hs;
  logic              in_fin;
  logic              out_fin;
  logic              finish;
  logic              abort;

  // Gating with aresetn keeps every output low during the reset cycle itself.
  assign run      = (state == RUN) && aresetn;
  assign in_done  = (in_cnt == IN_W'(FRAME_LEN));
  assign out_done = (out_cnt == OUT_W'(RESULT_LEN));

  always_comb begin
    logic [ID_W-1:0] idx;
    next_grant = rr_ptr;
    found      = 1'b0;
    idx        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && s_req_tvalid[idx]) begin
        found      = 1'b1;
        next_grant = idx;
      end
    end
  end

  always_comb begin
    s_req_tready = '0;
    if (run && !in_done) s_req_tready[grant] = core_in_tready;
  end

  assign core_in_tvalid  = run && !in_done && s_req_tvalid[grant];
  assign core_in_tdata   = run ? s_req_tdata[32*grant +: 32] : 32'd0;
  assign core_out_tready = run && !out_done && m_res_tready;
  assign m_res_tvalid    = run && !out_done && core_out_tvalid;
  assign m_res_tdata     = run ? core_out_tdata : 32'd0;
  assign m_res_tid       = run ? grant : '0;
  assign m_res_tlast     = run && (out_cnt == OUT_W'(RESULT_LEN - 1));
  assign busy            = run;

  assign in_hs   = core_in_tvalid && core_in_tready;
  assign out_hs  = m_res_tvalid && m_res_tready;
  // Completion looks one handshake ahead so a shared final cycle leaves RUN on that edge.
  assign in_fin  = in_done || (in_hs && (in_cnt == IN_W'(FRAME_LEN - 1)));
  assign out_fin = out_done || (out_hs && (out_cnt == OUT_W'(RESULT_LEN - 1)));
  assign finish  = run && in_fin && out_fin;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state   <= IDLE;
      grant   <= '0;
      rr_ptr  <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant <= next_grant;
            state <= RUN;
          end
        end
        RUN: begin
          if (finish || abort) begin
            state   <= IDLE;
            rr_ptr  <= ID_W'((int'(grant) + 1) % NUM_REQ);
            in_cnt  <= '0;
            out_cnt <= '0;
          end else begin
            if (in_hs)  in_cnt  <= in_cnt + IN_W'(1);
            if (out_hs) out_cnt <= out_cnt + OUT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SCHED_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [WD_W-1:0] wd_cnt;
  logic            to_q;

  // Down-counter reloads on every handshake and while idle; terminal count with no handshake aborts.
  assign abort       = run && !in_hs && !out_hs && (wd_cnt == '0);
  assign timeout_err = to_q && aresetn;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wd_cnt <= '0;
      to_q   <= 1'b0;
    end else begin
      to_q <= abort;
      if (state == IDLE || in_hs || out_hs) wd_cnt <= WD_W'(TIMEOUT_CYCLES - 1);
      else if (wd_cnt != '0)               wd_cnt <= wd_cnt - WD_W'(1);
    end
  end
`else
  assign abort       = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_axis_job_scheduler.sv
// Bench for axis_job_scheduler: job-level reference model checked every cycle plus directed literal checks.
// Timeout scenario is included when SCHED_TIMEOUT_EN is defined.
module tb_axis_job_scheduler;
  localparam int NR = 4, IDW = 2, F = 4, R = 4, T = 8;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic [NR-1:0]     s_req_tvalid, s_req_tready;
  logic [32*NR-1:0]  s_req_tdata;
  logic              core_in_tvalid, core_in_tready;
  logic [31:0]       core_in_tdata;
  logic              core_out_tvalid, core_out_tready;
  logic [31:0]       core_out_tdata;
  logic              m_res_tvalid, m_res_tready, m_res_tlast;
  logic [31:0]       m_res_tdata;
  logic [IDW-1:0]    m_res_tid;
  logic              busy, timeout_err;

  axis_job_scheduler #(.NUM_REQ(NR), .ID_W(IDW), .FRAME_LEN(F), .RESULT_LEN(R), .TIMEOUT_CYCLES(T)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_req_tvalid(s_req_tvalid), .s_req_tready(s_req_tready), .s_req_tdata(s_req_tdata),
    .core_in_tvalid(core_in_tvalid), .core_in_tready(core_in_tready), .core_in_tdata(core_in_tdata),
    .core_out_tvalid(core_out_tvalid), .core_out_tready(core_out_tready), .core_out_tdata(core_out_tdata),
    .m_res_tvalid(m_res_tvalid), .m_res_tready(m_res_tready), .m_res_tdata(m_res_tdata),
    .m_res_tid(m_res_tid), .m_res_tlast(m_res_tlast), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 aclk = ~aclk;

  int checks = 0, failures = 0;
  int cyc = 0;

  // requester sources: words appended by stimulus, consumed on handshake
  logic [31:0] src_data [NR][64];
  int          src_len [NR];
  int          src_rd  [NR] = '{default: 0};
  logic [NR-1:0] en;
  int          mode;   // 0: +1 with 3-cycle latency, 1: zero-latency echo, 2: never answers
  logic        m_rdy;

  logic [31:0] cq_data [256];
  int          cq_due  [256];
  int          cq_wr = 0, cq_rd = 0;

  logic [31:0]    res_data [$];
  logic [IDW-1:0] res_tid  [$];
  logic           res_last [$];
  logic [31:0]    cin      [$];
  int             grants   [$];
  int             to_pulses = 0;

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      s_req_tvalid[i]        = en[i] && (src_rd[i] < src_len[i]);
      s_req_tdata[32*i +: 32] = src_data[i][src_rd[i] % 64];
    end
  end

  assign m_res_tready    = m_rdy;
  assign core_in_tready  = (mode == 1) ? core_out_tready : 1'b1;
  assign core_out_tvalid = (mode == 1) ? core_in_tvalid
                         : ((mode == 0) && (cq_rd != cq_wr) && (cq_due[cq_rd % 256] <= cyc));
  assign core_out_tdata  = (mode == 1) ? core_in_tdata + 32'd1 : cq_data[cq_rd % 256];

  always @(posedge aclk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NR; i++)
      if (s_req_tvalid[i] && s_req_tready[i]) src_rd[i] <= src_rd[i] + 1;
    if (!aresetn) begin
      cq_rd <= cq_wr;
    end else begin
      if (core_in_tvalid && core_in_tready && mode != 1) begin
        cq_data[cq_wr % 256] <= core_in_tdata + 32'd1;
        cq_due[cq_wr % 256]  <= cyc + 3;
        cq_wr                <= cq_wr + 1;
      end
      if (core_out_tvalid && core_out_tready && mode == 0) cq_rd <= cq_rd + 1;
    end
    if (core_in_tvalid && core_in_tready) cin.push_back(core_in_tdata);
    if (m_res_tvalid && m_res_tready) begin
      res_data.push_back(m_res_tdata);
      res_tid.push_back(m_res_tid);
      res_last.push_back(m_res_tlast);
    end
    if (timeout_err) to_pulses <= to_pulses + 1;
  end

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int pick(int rr, logic [NR-1:0] v);
    for (int k = 0; k < NR; k++)
      if (v[(rr + k) % NR]) return (rr + k) % NR;
    return -1;
  endfunction

  // Job-level reference: who owns the core, how many words each way, where round-robin resumes.
  int m_active = 0, m_owner = 0, m_nin = 0, m_nout = 0, m_rr = 0, m_stall = 0;
  bit m_to_pend = 0;

  always @(negedge aclk) begin
    logic [NR-1:0]  e_rdy;
    logic           e_civ, e_cor, e_mv, e_last, e_busy, e_to, hs_in, hs_out;
    logic [31:0]    e_cid, e_md;
    logic [IDW-1:0] e_tid;
    int             p;
    e_rdy = '0; e_civ = 0; e_cor = 0; e_mv = 0; e_last = 0; e_busy = 0;
    e_cid = '0; e_md = '0; e_tid = '0; hs_in = 0; hs_out = 0; p = -1;
    e_to = m_to_pend;
    m_to_pend = 0;
    if (!aresetn) begin
      e_to = 0; m_active = 0; m_rr = 0; m_nin = 0; m_nout = 0; m_stall = 0;
    end else if (m_active != 0) begin
      e_busy = 1;
      e_tid  = IDW'(m_owner);
      e_civ  = s_req_tvalid[m_owner] && (m_nin < F);
      if (m_nin < F) e_rdy[m_owner] = core_in_tready;
      e_cid  = s_req_tdata[32*m_owner +: 32];
      e_mv   = core_out_tvalid && (m_nout < R);
      e_cor  = m_res_tready && (m_nout < R);
      e_md   = core_out_tdata;
      e_last = (m_nout == R - 1);
      hs_in  = e_civ && core_in_tready;
      hs_out = e_mv && m_res_tready;
      if (hs_in)  m_nin++;
      if (hs_out) m_nout++;
      if (m_nin == F && m_nout == R) begin
        m_active = 0;
        m_rr = (m_owner + 1) % NR;
      end
`ifdef SCHED_TIMEOUT_EN
      else if (hs_in || hs_out) m_stall = 0;
      else begin
        m_stall++;
        if (m_stall == T) begin
          m_active = 0;
          m_rr = (m_owner + 1) % NR;
          m_to_pend = 1;
        end
      end
`endif
    end else begin
      p = pick(m_rr, s_req_tvalid);
      if (p >= 0) begin
        m_active = 1; m_owner = p; m_nin = 0; m_nout = 0; m_stall = 0;
        grants.push_back(p);
      end
    end
    chk("s_req_tready", s_req_tready, e_rdy);
    chk("core_in_tvalid", core_in_tvalid, e_civ);
    chk("core_in_tdata", core_in_tdata, e_cid);
    chk("core_out_tready", core_out_tready, e_cor);
    chk("m_res_tvalid", m_res_tvalid, e_mv);
    chk("m_res_tdata", m_res_tdata, e_md);
    chk("m_res_tid", m_res_tid, e_tid);
    chk("m_res_tlast", m_res_tlast, e_last);
    chk("busy", busy, e_busy);
    chk("timeout_err", timeout_err, e_to);
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic load(int r, int base, int n);
    for (int k = 0; k < n; k++) begin
      src_data[r][src_len[r]] = 32'(base + k);
      src_len[r]++;
    end
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    tick();
    tick();
    aresetn = 1'b1;
  endtask

  task automatic clear_obs();
    res_data.delete(); res_tid.delete(); res_last.delete(); cin.delete(); grants.delete();
  endtask

  task automatic wait_res(int n, int budget, string name);
    int c = 0;
    while (res_data.size() < n && c < budget) begin
      tick();
      c++;
    end
    if (res_data.size() < n) chk(name, 64'(res_data.size()), 64'(n));
  endtask

  task automatic chk_job(string name, int first, int tid, int base);
    for (int b = 0; b < R; b++) begin
      chk({name, "_data"}, res_data[first + b], 64'(base + b + 1));
      chk({name, "_tid"},  res_tid[first + b], 64'(tid));
      chk({name, "_last"}, res_last[first + b], 64'(b == R - 1));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int exp_g2 [6];
    int base2  [NR];
    int exp_g3 [4];
    int base3  [NR];
    int g0, c;
    exp_g2 = '{0, 1, 3, 0, 1, 3};
    base2  = '{'h100, 'h200, 'h000, 'h300};
    exp_g3 = '{2, 3, 0, 1};
    base3  = '{'h500, 'h600, 'h400, 'h700};
    en = '0; mode = 0; m_rdy = 1'b1; aresetn = 1'b0;
    for (int i = 0; i < NR; i++) src_len[i] = 0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_s_req_tready", s_req_tready, 0);
    chk("rst_core_out_tready", core_out_tready, 0);
    chk("rst_m_res_tvalid", m_res_tvalid, 0);

    // single job from requester 2
    aresetn = 1'b1;
    clear_obs();
    load(2, 'h10, 4);
    en = 4'b0100;
    wait_res(4, 100, "t1_wait");
    chk_job("t1", 0, 2, 'h10);
    chk("t1_grant", grants[0], 2);
    for (int b = 0; b < F; b++) chk("t1_core_in", cin[b], 64'('h10 + b));
    tick();
    chk("t1_busy_after", busy, 0);

    // round-robin among 0, 1, 3
    do_reset();
    clear_obs();
    load(0, 'h100, 8); load(1, 'h200, 8); load(3, 'h300, 8);
    en = 4'b1011;
    wait_res(24, 400, "t2_wait");
    for (int j = 0; j < 6; j++) begin
      chk("t2_grant", grants[j], 64'(exp_g2[j]));
      chk_job("t2", 4 * j, exp_g2[j], base2[exp_g2[j]] + (j / 3) * 4);
    end

    // backpressure and requester gaps
    do_reset();
    clear_obs();
    load(2, 'h400, 4);
    en = 4'b0100;
    c = 0;
    while (!busy && c < 20) begin tick(); c++; end
    chk("t3_busy", busy, 1);
    load(0, 'h500, 4); load(1, 'h600, 4); load(3, 'h700, 4);
    en = 4'b1111;
    c = 0;
    while (res_data.size() < 16 && c < 600) begin
      m_rdy = (c % 4 == 0) || (c % 4 == 3);
      en[2] = (c % 3 != 2);
      tick();
      c++;
    end
    m_rdy = 1'b1;
    en = 4'b1111;
    chk("t3_count", res_data.size(), 16);
    for (int j = 0; j < 4; j++) begin
      chk("t3_grant", grants[j], 64'(exp_g3[j]));
      chk_job("t3", 4 * j, exp_g3[j], base3[exp_g3[j]]);
    end

    // zero-latency echo: last input and last result share a cycle
    do_reset();
    clear_obs();
    en = '0;
    mode = 1;
    load(1, 'h800, 4);
    en = 4'b0010;
    wait_res(4, 50, "t4_wait");
    chk("t4_busy_after", busy, 0);
    chk_job("t4", 0, 1, 'h800);
    load(1, 'h900, 4); load(2, 'hA00, 4);
    en = 4'b0110;
    wait_res(12, 100, "t4_wait2");
    chk("t4_grant_next", grants[1], 2);
    chk("t4_grant_last", grants[2], 1);
    chk_job("t4b", 4, 2, 'hA00);

    // reset in the middle of a job
    do_reset();
    clear_obs();
    en = '0;
    mode = 0;
    load(2, 'hB00, 4);
    en = 4'b0100;
    wait_res(4, 100, "t5_wait");
    load(3, 'hC00, 6);
    en = 4'b1000;
    cin.delete();
    c = 0;
    while (cin.size() < 2 && c < 50) begin tick(); c++; end
    chk("t5_cin", cin.size(), 2);
    aresetn = 1'b0;
    tick();
    chk("t5_busy", busy, 0);
    chk("t5_s_req_tready", s_req_tready, 0);
    chk("t5_core_in_tvalid", core_in_tvalid, 0);
    chk("t5_core_out_tready", core_out_tready, 0);
    chk("t5_m_res_tvalid", m_res_tvalid, 0);
    chk("t5_m_res_tid", m_res_tid, 0);
    chk("t5_m_res_tlast", m_res_tlast, 0);
    chk("t5_timeout_err", timeout_err, 0);
    aresetn = 1'b1;
    clear_obs();
    load(0, 'hD00, 4);
    en = 4'b1001;
    wait_res(8, 200, "t5_wait2");
    chk("t5_grant", grants[0], 0);
    chk_job("t5a", 0, 0, 'hD00);
    chk_job("t5b", 4, 3, 'hC02);

`ifdef SCHED_TIMEOUT_EN
    // core never answers: both jobs abort through the watchdog
    do_reset();
    clear_obs();
    en = '0;
    mode = 2;
    g0 = to_pulses;
    load(1, 'hE00, 4); load(2, 'hF00, 4);
    en = 4'b0110;
    c = 0;
    while (to_pulses - g0 < 2 && c < 200) begin tick(); c++; end
    tick();
    tick();
    chk("t6_pulses", to_pulses - g0, 2);
    chk("t6_grant0", grants[0], 1);
    chk("t6_grant1", grants[1], 2);
    chk("t6_results", res_data.size(), 0);
    mode = 0;
`else
    g0 = 0;
`endif

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
